// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Holds busy while working and pulses done for one cycle with the result and its rd tag.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCalc = 2'd1;
    localparam logic [1:0] StFix  = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [4:0]        rd_q, rd_d;
    logic              neg_q, neg_d;
    logic              a_neg_q, a_neg_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [XLEN:0]     rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              is_div, a_signed, b_signed, a_neg, b_neg;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   a_mag, b_mag, special_res;
    logic [XLEN:0]     mul_sum;
    logic [XLEN+1:0]   div_shift;
    logic [XLEN:0]     div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_val;

    // Operand decode and magnitudes, only meaningful at accept.
    always_comb begin
        is_div   = funct3[2];
        a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        a_neg    = a_signed & op_a[XLEN-1];
        b_neg    = b_signed & op_b[XLEN-1];
        a_mag    = a_neg ? ('0 - op_a) : op_a;
        b_mag    = b_neg ? ('0 - op_b) : op_b;
        div_zero = is_div && (op_b == '0);
        div_ovf  = is_div && !funct3[0] && (op_a == MinNeg) && (op_b == '1);
        if (div_zero) begin
            special_res = funct3[1] ? op_a : '1;
        end else begin
            special_res = funct3[1] ? '0 : MinNeg;
        end
    end

    // Datapath step and sign fix-up.
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, a_q};
        div_shift = {rem_q, quo_q[XLEN-1]};
        div_ge    = div_shift >= {2'b00, b_q};
        div_diff  = div_shift[XLEN:0] - {1'b0, b_q};
        prod_fix  = neg_q ? ('0 - prod_q) : prod_q;
        quo_fix   = neg_q ? ('0 - quo_q) : quo_q;
        rem_fix   = a_neg_q ? ('0 - rem_q[XLEN-1:0]) : rem_q[XLEN-1:0];
        case (op_q)
            3'b000:                   fix_val = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011:   fix_val = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:           fix_val = quo_fix;
            default:                  fix_val = rem_fix;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        neg_d    = neg_q;
        a_neg_d  = a_neg_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        result_d = result_q;
        if (flush) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        op_d    = funct3;
                        rd_d    = rd_in;
                        neg_d   = a_neg ^ b_neg;
                        a_neg_d = a_neg;
                        a_d     = a_mag;
                        b_d     = b_mag;
                        prod_d  = {{XLEN{1'b0}}, b_mag};
                        rem_d   = '0;
                        quo_d   = a_mag;
                        cnt_d   = 6'd32;
                        if (div_zero || div_ovf) begin
                            result_d = special_res;
                            state_d  = StDone;
                        end else begin
                            state_d = StCalc;
                        end
                    end
                end
                StCalc: begin
                    if (op_q[2]) begin
                        rem_d = div_ge ? div_diff : div_shift[XLEN:0];
                        quo_d = {quo_q[XLEN-2:0], div_ge};
                    end else begin
                        prod_d = prod_q[0] ? {mul_sum, prod_q[XLEN-1:1]}
                                           : {1'b0, prod_q[2*XLEN-1:1]};
                    end
                    cnt_d = cnt_q - 6'd1;
                    if (cnt_q == 6'd1) begin
                        state_d = StFix;
                    end
                end
                StFix: begin
                    result_d = fix_val;
                    state_d  = StDone;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            op_q     <= '0;
            rd_q     <= '0;
            neg_q    <= 1'b0;
            a_neg_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            prod_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            neg_q    <= neg_d;
            a_neg_q  <= a_neg_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StDone);
    assign result = result_q;
    assign rd_out = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: arithmetic, special cases,
// start handshake, flush and asynchronous reset.
module tb_muldiv_unit;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_in;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_cmp;
    int n_err;
    logic [31:0] last_exp;

    muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd_in  (rd_in),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negative edge with the unit idle; issues one op and waits for done.
    task automatic drive_wait(input string tag, input logic [2:0] f, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] rd,
                              input logic [31:0] exp, input int exp_lat);
        int n;
        int nb;
        start  = 1'b1;
        funct3 = f;
        op_a   = a;
        op_b   = b;
        rd_in  = rd;
        @(posedge clk);
        n  = 0;
        nb = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            n++;
            if (busy) nb++;
        end while (!done && n < 200);
        check_eq({tag, "_lat"}, 32'(n), 32'(exp_lat));
        check_eq({tag, "_res"}, result, exp);
        check_eq({tag, "_rd"}, {27'd0, rd_out}, {27'd0, rd});
        check_eq({tag, "_busy"}, 32'(nb), 32'(exp_lat));
        last_exp = exp;
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int exp_lat);
        @(negedge clk);
        drive_wait(tag, f, a, b, rd, exp, exp_lat);
    endtask

    initial begin
        int ndone;
        int done_cyc;
        int nbusy;
        n_cmp    = 0;
        n_err    = 0;
        last_exp = '0;
        rst      = 1'b1;
        start    = 1'b0;
        funct3   = '0;
        op_a     = '0;
        op_b     = '0;
        rd_in    = '0;
        flush    = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_result", result, 32'd0);
        check_eq("rst_rd", {27'd0, rd_out}, 32'd0);
        rst = 1'b0;

        run_op("mul",    F_MUL,    32'hFFFFFFFF, 32'h2, 5'd1, 32'hFFFFFFFE, 34);
        run_op("mulh",   F_MULH,   32'hFFFFFFFF, 32'h2, 5'd2, 32'hFFFFFFFF, 34);
        run_op("mulhu",  F_MULHU,  32'hFFFFFFFF, 32'h2, 5'd3, 32'h00000001, 34);
        run_op("mulhsu", F_MULHSU, 32'hFFFFFFFF, 32'h2, 5'd4, 32'hFFFFFFFF, 34);
        run_op("mul2",   F_MUL,    32'd12345,    32'd6789, 5'd5, 32'h04FED79D, 34);
        run_op("div",    F_DIV,    32'hFFFFFFF9, 32'h2, 5'd6, 32'hFFFFFFFD, 34);
        run_op("rem",    F_REM,    32'hFFFFFFF9, 32'h2, 5'd7, 32'hFFFFFFFF, 34);
        run_op("divu",   F_DIVU,   32'hFFFFFFF9, 32'h2, 5'd8, 32'h7FFFFFFC, 34);
        run_op("remu",   F_REMU,   32'hFFFFFFF9, 32'h2, 5'd9, 32'h00000001, 34);
        run_op("div2",   F_DIV,    32'd100,      32'hFFFFFFF9, 5'd10, 32'hFFFFFFF2, 34);
        run_op("rem2",   F_REM,    32'd100,      32'hFFFFFFF9, 5'd11, 32'h00000002, 34);
        run_op("divu0",  F_DIVU,   32'd5,        32'd0, 5'd12, 32'hFFFFFFFF, 1);
        run_op("rem0",   F_REM,    32'd5,        32'd0, 5'd13, 32'h00000005, 1);
        run_op("divovf", F_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, 1);
        run_op("removf", F_REM,    32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h00000000, 1);

        // Handshake: start held through the whole op, rd_in changes at cycle 10.
        @(negedge clk);
        start  = 1'b1;
        funct3 = F_MUL;
        op_a   = 32'd3;
        op_b   = 32'd5;
        rd_in  = 5'd7;
        @(posedge clk);
        ndone    = 0;
        done_cyc = 0;
        nbusy    = 0;
        for (int c = 1; c <= 35; c++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                done_cyc = c;
                check_eq("hs_rd_first", {27'd0, rd_out}, 32'd7);
            end
            if (c == 35) check_eq("hs_idle35", {31'd0, busy}, 32'd0);
            if (c == 10) rd_in = 5'd9;
        end
        check_eq("hs_ndone", 32'(ndone), 32'd1);
        check_eq("hs_done_cyc", 32'(done_cyc), 32'd34);
        check_eq("hs_busy_cnt", 32'(nbusy), 32'd34);
        check_eq("hs_res1", result, 32'd15);
        @(negedge clk);
        start = 1'b0;
        check_eq("hs_accept2_busy", {31'd0, busy}, 32'd1);
        check_eq("hs_rd_second", {27'd0, rd_out}, 32'd9);
        done_cyc = 0;
        for (int c = 0; c < 200 && done_cyc == 0; c++) begin
            @(negedge clk);
            if (done) done_cyc = c + 2;
        end
        check_eq("hs_done2_cyc", 32'(done_cyc), 32'd34);
        check_eq("hs_res2", result, 32'd15);
        last_exp = 32'd15;

        // Flush at cycle 15 of a DIV.
        @(negedge clk);
        start  = 1'b1;
        funct3 = F_DIV;
        op_a   = 32'd100;
        op_b   = 32'd7;
        rd_in  = 5'd3;
        @(posedge clk);
        ndone = 0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) ndone++;
            if (c == 15) flush = 1'b1;
        end
        @(negedge clk);
        flush = 1'b0;
        if (done) ndone++;
        check_eq("fl_idle", {31'd0, busy}, 32'd0);
        check_eq("fl_ndone", 32'(ndone), 32'd0);
        check_eq("fl_result", result, last_exp);
        check_eq("fl_rd", {27'd0, rd_out}, 32'd3);
        drive_wait("fl_next", F_DIVU, 32'd100, 32'd7, 5'd20, 32'd14, 34);

        // Asynchronous reset at cycle 20 of a MULHU.
        @(negedge clk);
        start  = 1'b1;
        funct3 = F_MULHU;
        op_a   = 32'hFFFFFFFF;
        op_b   = 32'hFFFFFFFF;
        rd_in  = 5'd5;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("ar_busy", {31'd0, busy}, 32'd0);
        check_eq("ar_done", {31'd0, done}, 32'd0);
        check_eq("ar_result", result, 32'd0);
        check_eq("ar_rd", {27'd0, rd_out}, 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        ndone = 0;
        nbusy = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
            if (busy) nbusy++;
        end
        check_eq("ar_ndone", 32'(ndone), 32'd0);
        check_eq("ar_nbusy", 32'(nbusy), 32'd0);
        run_op("ar_next", F_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 32'hFFFFFFFE, 34);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
